allstubs_reader: RTL and testbench
==================================

Name: allstubs_reader

Overview:
- Read-side engine for one AllStubs memory page set, paired with the AllStubs writer.
- On each new-BX strobe it walks the page of the current BX: issues `read_add = {bx, index}` for `index = 0..N-1`, absorbs the 2-cycle memory read latency, and presents the stubs downstream as a valid/ready stream.
- Sits between an AllStubs memory read port and a consumer stage (MatchCalculator / projection stage).

Parameters:
- MEM_SIZE, 5, per-BX stub index width; a page holds 2**MEM_SIZE entries.
- DATA_W, 36, stub word width.
- RD_LAT, 2, memory read latency in clocks (HIGH_PERFORMANCE RAM).
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LAT+2.
- TMUX, 4, start-to-done delay in clocks.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  2  [1] pipelined reset (synchronous), [0] new-BX strobe.
- done  out  2  start delayed by TMUX clocks.
- number_in  in  MEM_SIZE+1  stub count for the BX being read; sampled when start[0]=1.
- read_add  out  MEM_SIZE+5  memory read address {bx[4:0], index}.
- data_in  in  DATA_W  memory read data; valid RD_LAT clocks after read_add.
- data_out  out  DATA_W  stub word.
- valid_out  out  1  data_out valid.
- ready_in  in  1  consumer accepts data_out when valid_out & ready_in.
- truncated  out  1  one-cycle pulse: BX ended before all stubs were delivered.

Behaviour:
- Reset, asynchronous (reset=0) or start[1]=1:
  - bx=5'b11111, state=IDLE.
  - read_add=0, data_out=0, valid_out=0, truncated=0, done=0.
  - FIFO empty, in-flight pipeline cleared.
- bx increments on start[0] (wraps 31->0). The integration skews start so the reader's bx equals the page the writer just completed.
- On start[0]: latch `n = min(number_in, 2**MEM_SIZE-1)`, set index=0.
  - n>0 -> state READ.
  - n=0 -> state IDLE.
- READ:
  - Each clock where `occupancy + inflight < FIFO_DEPTH`, drive read_add={bx,index}, push a valid token into an RD_LAT-deep shift register, and increment index.
  - When index reaches n-1 and that read issues -> state DRAIN.
- DRAIN: when the token pipeline and FIFO are both empty -> IDLE.
- When a token emerges after RD_LAT clocks, data_in is written to the FIFO the same cycle.
- valid_out / data_out are registered from the FIFO head:
  - Read issued at cycle t gives valid_out at t+RD_LAT+1 earliest.
  - From start[0] at T with ready_in=1, the first read issues at T+1 and the first valid_out is at T+4. Thereafter one stub per clock.
- Backpressure:
  - ready_in=0 holds data_out/valid_out stable.
  - The credit check guarantees the FIFO never overflows. No stub is lost or duplicated.
- FIFO push and pop in the same cycle keep occupancy unchanged. Full/empty flags derive from a (log2 FIFO_DEPTH)+1-bit count.
- start[0] while state != IDLE (truncation):
  - Pulse truncated=1.
  - Flush the FIFO and invalidate all in-flight tokens (those data_in returns are dropped).
  - Then start the new BX in the same cycle: bx+1, latch the new n.
- start[0] coincident with start[1]: reset wins.
- read_add holds its last value when no read issues.

Optional Feature:
- Macro: ALLSTUBS_RD_LAST_EN.
- Defined: adds output `last_out` (1 bit, reset 0), asserted together with valid_out on the n-th (final) stub of a BX. Never asserted for n=0 or for a truncated BX.
- Undefined: no last_out port; all other behaviour is identical.

Test Plan:
- Basic read:
  - Stimulus: reset released; start=2'b01 at T with number_in=3, memory model RD_LAT=2, ready_in=1.
  - Response: read_add={bx=0, idx 0,1,2} at T+1..T+3; valid_out at T+4..T+6 with the stored words; done=2'b01 at T+TMUX.
- Empty BX:
  - Stimulus: number_in=0 on start[0].
  - Response: no read issued, valid_out stays 0, truncated=0.
- Backpressure:
  - Stimulus: number_in=10, ready_in toggling 1 clock high / 3 clocks low.
  - Response: all 10 words delivered in index order; FIFO occupancy never exceeds 4; no duplicates.
- Truncation:
  - Stimulus: number_in=20, ready_in=0, second start[0] 6 clocks later with number_in=2.
  - Response: truncated pulses once; then exactly the 2 words of the new bx delivered; no old-BX word appears.
- Reset and clamp:
  - Stimulus: start[1]=1 mid-READ; later number_in=63 with MEM_SIZE=5.
  - Response: after start[1], bx=31, outputs 0, idle. Then 31 reads, index 0..30.
- Wrap and optional feature:
  - Stimulus: 33 consecutive start[0] pulses; ALLSTUBS_RD_LAST_EN defined.
  - Response: bx wraps 31->0 in read_add[MEM_SIZE+4:MEM_SIZE]; last_out high only on the final stub of each BX.

Source files
------------

// File: rtl/allstubs_reader.sv
// allstubs_reader: walks one AllStubs page per BX and streams the stubs out
// through a credit-checked skid FIFO feeding a registered output stage.
// Ports: clk; reset (async, active-low); start[1] sync reset, start[0] new BX;
//   done = start delayed TMUX clocks; number_in = stub count of the BX;
//   read_add/data_in = memory read port {bx, index} with RD_LAT latency;
//   data_out/valid_out/ready_in = output stream; truncated = BX abandoned.
// Optional macro ALLSTUBS_RD_LAST_EN adds last_out on the final stub of a BX.
module allstubs_reader #(
    parameter int MEM_SIZE   = 5,
    parameter int DATA_W     = 36,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TMUX       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            start,
    output logic [1:0]            done,
    input  logic [MEM_SIZE:0]     number_in,
    output logic [MEM_SIZE+4:0]   read_add,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  truncated
`ifdef ALLSTUBS_RD_LAST_EN
    ,
    output logic                  last_out
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
`ifdef ALLSTUBS_RD_LAST_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [4:0]          bx_q;
    logic [MEM_SIZE-1:0] n_q, idx_q, n_next;
    logic [RD_LAT-1:0]   tok_q;
    logic [MEM_SIZE+4:0] add_q;
    logic [1:0]          dly_q [TMUX];

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt_q;
    logic [EW-1:0]       out_q, in_word;

    logic [CW:0]         inflight, used;
    logic new_bx, issue, is_last, emerge, load_out;
    logic fifo_pop, bypass, push, drained, trunc_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Numbers above the page capacity clamp to the last usable index.
    assign n_next = number_in[MEM_SIZE] ? '1 : number_in[MEM_SIZE-1:0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + (CW+1)'(tok_q[i]);
        end
    end

    // Credit: everything stored or still in the memory pipe must fit.
    assign used     = {1'b0, cnt_q} + (CW+1)'(valid_out) + inflight;
    assign new_bx   = start[0] & ~start[1];
    assign issue    = (state_q == READ) && (start == 2'b00) && (used < DEPTH_C);
    assign is_last  = (idx_q == n_q - 1'b1);
    assign emerge   = tok_q[RD_LAT-1] && (start == 2'b00);
    assign load_out = !valid_out || ready_in;
    assign fifo_pop = load_out && (cnt_q != '0);
    assign bypass   = load_out && (cnt_q == '0) && emerge;
    assign push     = emerge && !bypass;
    // Everything of this BX is delivered once this edge completes.
    assign drained  = (tok_q == '0) && (cnt_q == '0) && load_out;
    assign trunc_d  = new_bx && (state_q != IDLE) &&
                      !((state_q == DRAIN) && drained);

    assign read_add = issue ? {bx_q, idx_q} : add_q;
    assign data_out = out_q[DATA_W-1:0];
    assign done     = dly_q[TMUX-1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    ;
            READ:    if (issue && is_last) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_bx)   state_d = (n_next != '0) ? READ : IDLE;
        if (start[1]) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bx_q      <= '1;
            n_q       <= '0;
            idx_q     <= '0;
            tok_q     <= '0;
            add_q     <= '0;
            truncated <= 1'b0;
        end else if (start[1]) begin
            bx_q      <= '1;
            n_q       <= '0;
            idx_q     <= '0;
            tok_q     <= '0;
            add_q     <= '0;
            truncated <= 1'b0;
        end else begin
            truncated <= trunc_d;
            if (new_bx) begin
                bx_q  <= bx_q + 5'd1;
                n_q   <= n_next;
                idx_q <= '0;
                tok_q <= '0;
            end else begin
                tok_q <= {tok_q[RD_LAT-2:0], issue};
                if (issue) begin
                    idx_q <= idx_q + 1'b1;
                    add_q <= {bx_q, idx_q};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= in_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            valid_out <= 1'b0;
            out_q     <= '0;
        end else if (start[1]) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            valid_out <= 1'b0;
            out_q     <= '0;
        end else if (new_bx) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            valid_out <= 1'b0;
        end else begin
            if (push)     wr_ptr <= nxt(wr_ptr);
            if (fifo_pop) rd_ptr <= nxt(rd_ptr);
            unique case ({push, fifo_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            // Memory data may skip the FIFO when it is empty.
            if (load_out) begin
                valid_out <= fifo_pop | bypass;
                if (fifo_pop)    out_q <= mem_q[rd_ptr];
                else if (bypass) out_q <= in_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TMUX; i++) dly_q[i] <= 2'b00;
        end else begin
            dly_q[0] <= start;
            for (int i = 1; i < TMUX; i++) begin
                dly_q[i] <= start[1] ? 2'b00 : dly_q[i-1];
            end
        end
    end

`ifdef ALLSTUBS_RD_LAST_EN
    logic [RD_LAT-1:0] tok_last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_last_q <= '0;
        end else if (start != 2'b00) begin
            tok_last_q <= '0;
        end else begin
            tok_last_q <= {tok_last_q[RD_LAT-2:0], issue && is_last};
        end
    end

    assign in_word  = {tok_last_q[RD_LAT-1], data_in};
    assign last_out = valid_out & out_q[DATA_W];
`else
    assign in_word  = data_in;
`endif

endmodule

// File: tb/tb_allstubs_reader.sv
// tb_allstubs_reader: randomized and directed bench for allstubs_reader with
// a queue-based model of the stubs each BX must deliver.
module tb_allstubs_reader;
    localparam int MS = 5;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    start;
    logic [1:0]    done;
    logic [MS:0]   number_in;
    logic [MS+4:0] read_add;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          truncated;
`ifdef ALLSTUBS_RD_LAST_EN
    logic          last_out;
`endif

    allstubs_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .number_in (number_in),
        .read_add  (read_add),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .truncated (truncated)
`ifdef ALLSTUBS_RD_LAST_EN
        ,
        .last_out  (last_out)
`endif
    );

    always #5 clk = ~clk;

    // Memory with 2-clock read latency.
    logic [DW-1:0] mem [0:1023];
    logic [9:0]    a1, a2;
    always @(posedge clk) begin
        a1 <= read_add;
        a2 <= a1;
    end
    assign data_in = mem[a2];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] w;
        logic          last;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sh[$];
    logic [4:0] bxm = 5'd31;
    logic       exp_trunc = 1'b0;
    logic [1:0] dexp;
    int         cyc = 0;
    int         nm;
    bit         run = 0;

    always @(negedge clk) begin
        if (run) begin
            dexp = 2'b00;
            if (cyc >= 4) begin
                dexp = sh[cyc-4];
                for (int k = 1; k <= 3; k++) begin
                    if (sh[cyc-k][1]) dexp = 2'b00;
                end
            end
            check("done", done, dexp);
            check("truncated", truncated, exp_trunc);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", valid_out, 1'b0);
                end else begin
                    check("data_out", data_out, exp_q[0].w);
`ifdef ALLSTUBS_RD_LAST_EN
                    check("last_out", last_out, exp_q[0].last);
`endif
                    if (ready_in) void'(exp_q.pop_front());
                end
            end
`ifdef ALLSTUBS_RD_LAST_EN
            else check("last_idle", last_out, 1'b0);
`endif
            exp_trunc = 1'b0;
            if (start[1]) begin
                exp_q.delete();
                bxm = 5'd31;
            end else if (start[0]) begin
                exp_trunc = (exp_q.size() != 0);
                exp_q.delete();
                bxm = bxm + 5'd1;
                nm = (int'(number_in) > 31) ? 31 : int'(number_in);
                for (int i = 0; i < nm; i++) begin
                    exp_q.push_back('{mem[{bxm, 5'(i)}], (i == nm - 1)});
                end
            end
            sh.push_back(start);
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] s, input int n);
        start     = s;
        number_in = 6'(n);
        step();
        start     = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {4'($urandom), 32'($urandom)};
        reset = 1'b0;
        start = 2'b00;
        number_in = '0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_data", data_out, '0);
        check("rst_add", read_add, '0);
        check("rst_done", done, 2'b00);
        check("rst_trunc", truncated, 1'b0);
        reset = 1'b1;
        run = 1;
        step();
        step();

        // Basic read of 3 stubs.
        go(2'b01, 3);
        @(negedge clk); check("rd_idx0", read_add, 10'd0);
        step();
        @(negedge clk); check("rd_idx1", read_add, 10'd1);
        step();
        @(negedge clk); check("rd_idx2", read_add, 10'd2);
        check("early_valid", valid_out, 1'b0);
        step();
        @(negedge clk); check("first_valid", valid_out, 1'b1);
        check("done_t4", done, 2'b01);
        repeat (6) step();

        // Empty BX: no read, address holds.
        go(2'b01, 0);
        repeat (5) begin
            @(negedge clk); check("hold_add", read_add, 10'd2);
            step();
        end

        // Backpressure: 1 high / 3 low.
        go(2'b01, 10);
        for (int c = 0; c < 80; c++) begin
            ready_in = (c % 4 == 0);
            step();
        end

        // Truncation.
        ready_in = 1'b0;
        go(2'b01, 20);
        repeat (5) step();
        go(2'b01, 2);
        ready_in = 1'b1;
        @(negedge clk); check("trunc_pulse", truncated, 1'b1);
        repeat (10) step();

        // Pipelined reset mid-READ, then clamp.
        go(2'b01, 10);
        step();
        step();
        go(2'b10, 0);
        @(negedge clk);
        check("sr_valid", valid_out, 1'b0);
        check("sr_add", read_add, '0);
        check("sr_data", data_out, '0);
        check("sr_trunc", truncated, 1'b0);
        step();
        go(2'b01, 63);
        repeat (45) step();
        go(2'b01, 5);
        step();
        go(2'b11, 7);
        repeat (10) step();

        // 33 back-to-back BX strobes, then random traffic.
        for (int p = 0; p < 33; p++) begin
            start = 2'b01;
            number_in = 6'($urandom_range(0, 63));
            ready_in = ($urandom_range(0, 3) != 0);
            step();
        end
        start = 2'b00;
        for (int p = 0; p < 40; p++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(2, 45));
            go(2'b01, int'($urandom_range(0, 63)));
            for (int g = 1; g < gap; g++) begin
                ready_in = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        // Drain with a bounded wait.
        ready_in = 1'b1;
        for (int w = 0; w < 500; w++) begin
            if (exp_q.size() == 0 && !valid_out) break;
            step();
        end
        step();
        check("drained", exp_q.size(), 0);
        check("final_valid", valid_out, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
